// File: rtl/eth_pkg.sv
// Shared definitions for the Ethernet command receive path.
// Latency: n/a (constants, types and one helper function only).
// Backpressure: n/a.
package eth_pkg;

    // Command codes carried in the command byte and presented on cmd
    localparam logic [2:0] CMD_NONE     = 3'd0;
    localparam logic [2:0] CMD_SDRAM_RD = 3'd1;
    localparam logic [2:0] CMD_REG_RD   = 3'd2;
    localparam logic [2:0] CMD_REG_WR   = 3'd3;

    localparam logic [15:0] DEF_ETHERTYPE = 16'h88B5;
    localparam logic [47:0] BCAST_MAC     = 48'hFFFF_FFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_PAY,
        ST_SKIP,
        ST_DROP,
        ST_ISSUE
    } state_t;

    // Byte k (0 = most significant, as sent on the wire) of a MAC address;
    // returns 0 for k outside the 6-byte address.
    function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [4:0] k);
        logic [7:0] b;
        b = 8'h00;
        for (int i = 0; i < 6; i++) begin
            if (k == 5'(i)) b = mac[8*(5-i) +: 8];
        end
        return b;
    endfunction

endpackage

// File: rtl/eth_cmd_decoder.sv
// Receive-side command decoder: filters frames, extracts cmd/address/value, latches sender MAC.
// Latency: cmd valid one cycle after the accepted tlast beat; drop_cnt updates one cycle after a dropping tlast.
// Backpressure: rx_tready is registered low only while a command waits for ready4cmd.
//
// Ports: clk125/reset (async, active-high); rx_t* byte-wide AXI-Stream sink from the MAC FIFO;
// cmd/address/value/src_mac command outputs consumed by ready4cmd; drop_cnt wrapping drop counter.
// Build option: define ETH_CMD_MACFILTER_EN to require destination MAC == MY_MAC or broadcast.
module eth_cmd_decoder
    import eth_pkg::*;
#(
    parameter logic [47:0] MY_MAC    = 48'h02_00_00_00_00_01,
    parameter logic [15:0] ETHERTYPE = DEF_ETHERTYPE
) (
    input  logic        clk125,
    input  logic        reset,
    input  logic [7:0]  rx_tdata,
    input  logic        rx_tvalid,
    output logic        rx_tready,
    input  logic        rx_tlast,
    input  logic        rx_tuser,
    output logic [2:0]  cmd,
    output logic [31:0] address,
    output logic [31:0] value,
    input  logic        ready4cmd,
    output logic [47:0] src_mac,
    output logic [15:0] drop_cnt
);

`ifdef ETH_CMD_MACFILTER_EN
    localparam bit FILTER_EN = 1'b1;
`else
    localparam bit FILTER_EN = 1'b0;
`endif

    state_t      state;
    logic [4:0]  k;          // index of the next byte of the frame, saturates at 23
    logic        uc_ok;      // destination bytes so far match MY_MAC
    logic        bc_ok;      // destination bytes so far match broadcast
    logic [2:0]  cmd_sh;
    logic [31:0] addr_sh;
    logic [31:0] val_sh;
    logic [47:0] mac_sh;

    logic        beat;
    logic        uc_nxt, bc_nxt;
    logic        dest_bad, etype_bad, hdr_bad, cmd_bad;
    logic [31:0] val_cap;

    always_comb begin
        beat = rx_tvalid && rx_tready;
        // Match flags restart at every frame: IDLE always sees byte 0.
        uc_nxt = ((state == ST_IDLE) || uc_ok) && (rx_tdata == mac_byte(MY_MAC, k));
        bc_nxt = ((state == ST_IDLE) || bc_ok) && (rx_tdata == mac_byte(BCAST_MAC, k));
        dest_bad  = FILTER_EN && (k <= 5'd5) && !uc_nxt && !bc_nxt;
        etype_bad = ((k == 5'd12) && (rx_tdata != ETHERTYPE[15:8])) ||
                    ((k == 5'd13) && (rx_tdata != ETHERTYPE[7:0]));
        hdr_bad   = dest_bad || etype_bad;
        cmd_bad   = (k == 5'd14) &&
                    ((rx_tdata == 8'(CMD_NONE)) || (rx_tdata > 8'(CMD_REG_WR)));
        // At k22 the last value byte arrives together with tlast, so bypass the shadow.
        val_cap = (state == ST_PAY) ? {val_sh[23:0], rx_tdata} : val_sh;
    end

    always_ff @(posedge clk125 or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            k         <= 5'd0;
            uc_ok     <= 1'b0;
            bc_ok     <= 1'b0;
            cmd_sh    <= CMD_NONE;
            addr_sh   <= 32'd0;
            val_sh    <= 32'd0;
            mac_sh    <= 48'd0;
            rx_tready <= 1'b1;
            cmd       <= CMD_NONE;
            address   <= 32'd0;
            value     <= 32'd0;
            src_mac   <= 48'd0;
            drop_cnt  <= 16'd0;
        end else begin
            if (beat && (k != 5'd23)) k <= k + 5'd1;

            case (state)
                ST_IDLE, ST_HDR: if (beat) begin
                    uc_ok <= uc_nxt;
                    bc_ok <= bc_nxt;
                    if ((k >= 5'd6) && (k <= 5'd11)) mac_sh <= {mac_sh[39:0], rx_tdata};
                    if (rx_tlast) begin
                        state    <= ST_IDLE;
                        k        <= 5'd0;
                        drop_cnt <= drop_cnt + 16'd1;
                    end else if (hdr_bad) begin
                        state <= ST_DROP;
                    end else if (k == 5'd13) begin
                        state <= ST_PAY;
                    end else begin
                        state <= ST_HDR;
                    end
                end

                ST_PAY: if (beat) begin
                    if (k == 5'd14) cmd_sh <= rx_tdata[2:0];
                    if ((k >= 5'd15) && (k <= 5'd18)) addr_sh <= {addr_sh[23:0], rx_tdata};
                    if (k >= 5'd19) val_sh <= {val_sh[23:0], rx_tdata};
                    if (rx_tlast) begin
                        k <= 5'd0;
                        if ((k == 5'd22) && !rx_tuser) begin
                            state     <= ST_ISSUE;
                            rx_tready <= 1'b0;
                            cmd       <= cmd_sh;
                            address   <= addr_sh;
                            value     <= val_cap;
                            src_mac   <= mac_sh;
                        end else begin
                            state    <= ST_IDLE;
                            drop_cnt <= drop_cnt + 16'd1;
                        end
                    end else if (cmd_bad) begin
                        state <= ST_DROP;
                    end else if (k == 5'd22) begin
                        state <= ST_SKIP;
                    end
                end

                ST_SKIP: if (beat && rx_tlast) begin
                    k <= 5'd0;
                    if (!rx_tuser) begin
                        state     <= ST_ISSUE;
                        rx_tready <= 1'b0;
                        cmd       <= cmd_sh;
                        address   <= addr_sh;
                        value     <= val_cap;
                        src_mac   <= mac_sh;
                    end else begin
                        state    <= ST_IDLE;
                        drop_cnt <= drop_cnt + 16'd1;
                    end
                end

                ST_DROP: if (beat && rx_tlast) begin
                    state    <= ST_IDLE;
                    k        <= 5'd0;
                    drop_cnt <= drop_cnt + 16'd1;
                end

                ST_ISSUE: if (ready4cmd) begin
                    state     <= ST_IDLE;
                    k         <= 5'd0;
                    rx_tready <= 1'b1;
                    cmd       <= CMD_NONE;
                end

                default: begin
                    state     <= ST_IDLE;
                    k         <= 5'd0;
                    rx_tready <= 1'b1;
                    cmd       <= CMD_NONE;
                end
            endcase
        end
    end

endmodule
